// File: rtl/pc_fetch_controller.sv
// Instruction fetch controller: one outstanding imem request, single-entry decode buffer, prioritised PC redirects.
// Optional macro PC_MISALIGN_TRAP_EN reroutes misaligned redirect targets to i_trap_vec and pulses o_misalign.
module pc_fetch_controller #(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = 32'h4000_0000
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic [XLEN-1:0] i_pc_curr,
  output logic            o_pc_write,
  output logic [XLEN-1:0] o_pc_next,
  output logic            o_imem_req,
  output logic [XLEN-1:0] o_imem_addr,
  input  logic            i_imem_gnt,
  input  logic            i_imem_rvalid,
  input  logic [31:0]     i_imem_rdata,
  output logic            o_instr_valid,
  output logic [31:0]     o_instr,
  output logic [XLEN-1:0] o_instr_pc,
  input  logic            i_instr_ready,
  input  logic            i_trap,
  input  logic [XLEN-1:0] i_trap_vec,
  input  logic            i_mret,
  input  logic [XLEN-1:0] i_mepc,
  input  logic            i_br_taken,
  input  logic [XLEN-1:0] i_br_target,
  output logic            o_misalign
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_VALID
  } state_e;

  state_e          state_q, state_d;
  logic            discard_q, discard_d;
  logic [31:0]     instr_q, instr_d;
  logic [XLEN-1:0] instr_pc_q, instr_pc_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;

  logic            redirect;
  logic            misalign;
  logic [XLEN-1:0] sel_target;
  logic [XLEN-1:0] redir_target;

  // Redirects are gated by reset so the PC outputs stay at their reset values.
  assign redirect = i_rst_n & (i_trap | i_mret | i_br_taken);

  always_comb begin
    sel_target = i_br_target;
    if (i_mret) sel_target = i_mepc;
    if (i_trap) sel_target = i_trap_vec;
  end

`ifdef PC_MISALIGN_TRAP_EN
  assign misalign     = redirect & (sel_target[1:0] != 2'b00);
  assign redir_target = misalign ? i_trap_vec : sel_target;
`else
  assign misalign     = 1'b0;
  assign redir_target = sel_target;
`endif

  assign o_misalign  = misalign;
  assign o_imem_addr = i_pc_curr;
  assign o_instr     = instr_q;
  assign o_instr_pc  = instr_pc_q;

  always_comb begin
    state_d       = state_q;
    discard_d     = discard_q;
    instr_d       = instr_q;
    instr_pc_d    = instr_pc_q;
    fetch_pc_d    = fetch_pc_q;
    o_imem_req    = 1'b0;
    o_instr_valid = 1'b0;
    o_pc_write    = 1'b0;
    o_pc_next     = RESET_PC;

    case (state_q)
      S_IDLE: begin
        state_d = S_REQ;
      end
      S_REQ: begin
        o_imem_req = 1'b1;
        if (i_imem_gnt) begin
          fetch_pc_d = i_pc_curr;
          discard_d  = redirect;
          state_d    = S_WAIT;
        end
      end
      S_WAIT: begin
        // Stay here until the outstanding response returns, even when it is to be dropped.
        if (redirect) discard_d = 1'b1;
        if (i_imem_rvalid) begin
          discard_d = 1'b0;
          if (discard_q || redirect) begin
            state_d = S_REQ;
          end else begin
            instr_d    = i_imem_rdata;
            instr_pc_d = fetch_pc_q;
            state_d    = S_VALID;
          end
        end
      end
      S_VALID: begin
        o_instr_valid = 1'b1;
        if (redirect) begin
          instr_d    = '0;
          instr_pc_d = '0;
          state_d    = S_REQ;
        end else if (i_instr_ready) begin
          o_pc_write = 1'b1;
          o_pc_next  = instr_pc_q + XLEN'(4);
          state_d    = S_REQ;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (redirect) begin
      o_pc_write = 1'b1;
      o_pc_next  = redir_target;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= S_IDLE;
      discard_q  <= 1'b0;
      instr_q    <= '0;
      instr_pc_q <= '0;
      fetch_pc_q <= '0;
    end else begin
      state_q    <= state_d;
      discard_q  <= discard_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
      fetch_pc_q <= fetch_pc_d;
    end
  end

endmodule

// File: tb/tb_pc_fetch_controller.sv
// Directed bench for pc_fetch_controller: transaction-level model checked every cycle plus literal spot checks.
module tb_pc_fetch_controller;

  localparam logic [31:0] RST_PC = 32'h4000_0000;

  logic        clk;
  logic        rst_n;
  logic [31:0] pc_env;
  logic        o_pc_write;
  logic [31:0] o_pc_next;
  logic        o_imem_req;
  logic [31:0] o_imem_addr;
  logic        gnt, rvalid;
  logic [31:0] rdata;
  logic        o_instr_valid;
  logic [31:0] o_instr;
  logic [31:0] o_instr_pc;
  logic        ready;
  logic        trap, mret, br;
  logic [31:0] trap_vec, mepc, br_target;
  logic        o_misalign;

  int n_vec = 0;
  int n_err = 0;

  pc_fetch_controller #(
    .XLEN    (32),
    .RESET_PC(RST_PC)
  ) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_pc_curr    (pc_env),
    .o_pc_write   (o_pc_write),
    .o_pc_next    (o_pc_next),
    .o_imem_req   (o_imem_req),
    .o_imem_addr  (o_imem_addr),
    .i_imem_gnt   (gnt),
    .i_imem_rvalid(rvalid),
    .i_imem_rdata (rdata),
    .o_instr_valid(o_instr_valid),
    .o_instr      (o_instr),
    .o_instr_pc   (o_instr_pc),
    .i_instr_ready(ready),
    .i_trap       (trap),
    .i_trap_vec   (trap_vec),
    .i_mret       (mret),
    .i_mepc       (mepc),
    .i_br_taken   (br),
    .i_br_target  (br_target),
    .o_misalign   (o_misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Program counter register owned by the environment.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) pc_env <= RST_PC;
    else if (o_pc_write) pc_env <= o_pc_next;
  end

  // Transaction model: started / request in flight / drop pending / instruction held.
  logic        m_started, m_busy, m_drop, m_has;
  logic [31:0] m_fpc, m_instr, m_ipc;
  logic        redir;
  assign redir = trap | mret | br;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_started <= 1'b0;
      m_busy    <= 1'b0;
      m_drop    <= 1'b0;
      m_has     <= 1'b0;
      m_fpc     <= '0;
      m_instr   <= '0;
      m_ipc     <= '0;
    end else if (!m_started) begin
      m_started <= 1'b1;
    end else if (m_has) begin
      if (redir || ready) m_has <= 1'b0;
    end else if (m_busy) begin
      if (rvalid) begin
        m_busy <= 1'b0;
        m_drop <= 1'b0;
        if (!m_drop && !redir) begin
          m_has   <= 1'b1;
          m_instr <= rdata;
          m_ipc   <= m_fpc;
        end
      end else if (redir) begin
        m_drop <= 1'b1;
      end
    end else if (gnt) begin
      m_busy <= 1'b1;
      m_fpc  <= pc_env;
      m_drop <= redir;
    end
  end

  logic [31:0] e_target;
  logic        e_mis, e_req, e_write;

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_req", o_imem_req, 0);
      chk("rst_valid", o_instr_valid, 0);
      chk("rst_write", o_pc_write, 0);
      chk("rst_next", o_pc_next, RST_PC);
      chk("rst_instr", o_instr, 0);
      chk("rst_instr_pc", o_instr_pc, 0);
      chk("rst_misalign", o_misalign, 0);
    end else begin
      e_target = trap ? trap_vec : (mret ? mepc : br_target);
      e_mis    = 1'b0;
`ifdef PC_MISALIGN_TRAP_EN
      if (redir && e_target[1:0] != 2'b00) begin
        e_target = trap_vec;
        e_mis    = 1'b1;
      end
`endif
      e_req   = m_started && !m_busy && !m_has;
      e_write = redir || (m_has && ready);
      chk("req", o_imem_req, e_req);
      if (e_req) chk("addr", o_imem_addr, pc_env);
      chk("valid", o_instr_valid, m_has);
      if (m_has) begin
        chk("instr", o_instr, m_instr);
        chk("instr_pc", o_instr_pc, m_ipc);
      end
      chk("write", o_pc_write, e_write);
      if (e_write) chk("next", o_pc_next, redir ? e_target : m_ipc + 32'd4);
      chk("misalign", o_misalign, e_mis);
    end
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; gnt = 0; rvalid = 0; rdata = '0; ready = 0;
    trap = 0; mret = 0; br = 0; trap_vec = '0; mepc = '0; br_target = '0;
    repeat (3) nxt();

    // Reset release: one IDLE cycle, then request at RESET_PC.
    rst_n = 1'b1;
    @(negedge clk);
    chk("lit_idle_req", o_imem_req, 0);
    nxt();
    gnt = 1;
    @(negedge clk);
    chk("lit_first_req", o_imem_req, 1);
    chk("lit_first_addr", o_imem_addr, 32'h4000_0000);
    nxt();
    gnt = 0; rvalid = 1; rdata = 32'h0000_0013;
    @(negedge clk);
    chk("lit_wait_req", o_imem_req, 0);
    nxt();
    rvalid = 0; ready = 1;
    @(negedge clk);
    chk("lit_valid_n2", o_instr_valid, 1);
    chk("lit_instr", o_instr, 32'h0000_0013);
    chk("lit_seq_next", o_pc_next, 32'h4000_0004);
    chk("lit_seq_write", o_pc_write, 1);
    nxt();

    // Stall for five cycles in VALID.
    ready = 0; gnt = 1;
    @(negedge clk);
    chk("lit_addr_4", o_imem_addr, 32'h4000_0004);
    nxt();
    gnt = 0; rvalid = 1; rdata = 32'h0010_0093;
    nxt();
    rvalid = 0; ready = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("lit_stall_instr", o_instr, 32'h0010_0093);
      chk("lit_stall_write", o_pc_write, 0);
      nxt();
    end
    ready = 1;
    @(negedge clk);
    chk("lit_stall_next", o_pc_next, 32'h4000_0008);
    nxt();
    ready = 0;

    // Branch while waiting: response dropped, refetch at target.
    gnt = 1;
    nxt();
    gnt = 0; br = 1; br_target = 32'h4000_0100;
    @(negedge clk);
    chk("lit_br_write", o_pc_write, 1);
    chk("lit_br_next", o_pc_next, 32'h4000_0100);
    nxt();
    br = 0; rvalid = 1; rdata = 32'hDEAD_BEEF;
    nxt();
    rvalid = 0;
    @(negedge clk);
    chk("lit_drop_valid", o_instr_valid, 0);
    chk("lit_br_addr", o_imem_addr, 32'h4000_0100);

    // mret while requesting without grant.
    mret = 1; mepc = 32'h4000_0200;
    @(negedge clk);
    chk("lit_mret_next", o_pc_next, 32'h4000_0200);
    nxt();
    mret = 0;
    @(negedge clk);
    chk("lit_mret_addr", o_imem_addr, 32'h4000_0200);
    gnt = 1;
    nxt();
    gnt = 0; rvalid = 1; rdata = 32'h0000_0513;
    nxt();

    // All three redirects in VALID with ready: trap wins, no +4.
    rvalid = 0; ready = 1;
    trap = 1; trap_vec = 32'h0000_0080;
    mret = 1; mepc = 32'h4000_0300;
    br = 1; br_target = 32'h4000_0400;
    @(negedge clk);
    chk("lit_prio_next", o_pc_next, 32'h0000_0080);
    nxt();
    trap = 0; mret = 0; br = 0; ready = 0;
    @(negedge clk);
    chk("lit_flush_valid", o_instr_valid, 0);
    chk("lit_trap_addr", o_imem_addr, 32'h0000_0080);

    // Branch coincident with grant, response one cycle late.
    gnt = 1; br = 1; br_target = 32'h0000_0200;
    nxt();
    gnt = 0; br = 0;
    nxt();
    rvalid = 1; rdata = 32'h1111_1111;
    nxt();
    rvalid = 0;
    @(negedge clk);
    chk("lit_gntbr_valid", o_instr_valid, 0);
    chk("lit_gntbr_addr", o_imem_addr, 32'h0000_0200);

    // Misaligned branch target.
    br = 1; br_target = 32'h4000_0102;
    @(negedge clk);
`ifdef PC_MISALIGN_TRAP_EN
    chk("lit_mis_next", o_pc_next, 32'h0000_0080);
    chk("lit_mis_pulse", o_misalign, 1);
`else
    chk("lit_mis_next", o_pc_next, 32'h4000_0102);
    chk("lit_mis_pulse", o_misalign, 0);
`endif
    nxt();
    br = 0;
    @(negedge clk);
    chk("lit_mis_end", o_misalign, 0);
    br = 1; br_target = 32'h4000_0500;
    nxt();
    br = 0;

    // Reset mid-fetch, stale responses after release.
    gnt = 1;
    nxt();
    gnt = 0;
    rst_n = 1'b0;
    nxt();
    rst_n = 1'b1;
    br = 1; br_target = 32'h4000_0600;
    rvalid = 1; rdata = 32'h0BAD_0BAD;
    @(negedge clk);
    chk("lit_idle_br_next", o_pc_next, 32'h4000_0600);
    nxt();
    br = 0;
    @(negedge clk);
    chk("lit_rst_addr", o_imem_addr, 32'h4000_0600);
    chk("lit_rst_valid", o_instr_valid, 0);
    nxt();
    rvalid = 0; gnt = 1;
    nxt();
    gnt = 0;
    nxt();
    rvalid = 1; rdata = 32'h00A0_0093;
    nxt();
    rvalid = 0; ready = 1;
    @(negedge clk);
    chk("lit_final_instr", o_instr, 32'h00A0_0093);
    chk("lit_final_pc", o_instr_pc, 32'h4000_0600);
    chk("lit_final_next", o_pc_next, 32'h4000_0604);
    nxt();
    ready = 0;
    repeat (2) nxt();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pc_fetch_controller.md
PC_FETCH_CONTROLLER -- requirements
Module: pc_fetch_controller

Interface
REQ-001 Parameter XLEN, default 32, datapath and address width.
REQ-002 Parameter RESET_PC, default 32'h4000_0000, PC value held while in reset.
REQ-003 i_clk  input  1  single clock; all state updates on its rising edge.
REQ-004 i_rst_n  input  1  reset; asynchronous, active-low.
REQ-005 i_pc_curr  input  XLEN  current PC from the program counter register.
REQ-006 o_pc_write  output  1  PC update enable to the program counter register.
REQ-007 o_pc_next  output  XLEN  next PC value to the program counter register.
REQ-008 o_imem_req / o_imem_addr  output  1 / XLEN  fetch request; o_imem_addr = i_pc_curr.
REQ-009 i_imem_gnt / i_imem_rvalid / i_imem_rdata  input  1 / 1 / 32  grant, response valid, response data.
REQ-010 o_instr_valid / o_instr / o_instr_pc  output  1 / 32 / XLEN  instruction to decode.
REQ-011 i_instr_ready  input  1  decode accepts the instruction; low = stall.
REQ-012 i_trap / i_trap_vec, i_mret / i_mepc, i_br_taken / i_br_target  input  1 / XLEN each  redirect requests with target PC.
REQ-013 o_misalign  output  1  one-cycle pulse on a misaligned redirect target (present only with PC_MISALIGN_TRAP_EN).

Function
REQ-014 FSM states: IDLE, REQ, WAIT, VALID; at most one imem request outstanding.
REQ-015 IDLE: entered on reset; goes to REQ on the first clock edge after reset deasserts.
REQ-016 REQ: o_imem_req=1; on i_imem_gnt go to WAIT; the address is sampled by imem only on the grant cycle.
REQ-017 WAIT: o_imem_req=0; on i_imem_rvalid, latch rdata and the fetch PC into the buffer, then go to VALID.
REQ-018 VALID: o_instr_valid=1 from the buffer; on i_instr_ready, pulse o_pc_write with o_pc_next = o_instr_pc + 4 (modulo 2^XLEN), then go to REQ.
REQ-019 Redirect: any of i_trap, i_mret or i_br_taken asserted in a cycle.
REQ-020 Redirect priority: trap > mret > branch > sequential +4.
REQ-021 Redirect response: o_pc_write=1 and o_pc_next = selected target in the same cycle, combinationally.
REQ-022 Redirect in REQ without grant: stay in REQ; the request continues with the new PC.
REQ-023 Redirect in REQ with grant, or in WAIT: set a discard flag; the matching rvalid is dropped; then go to REQ.
REQ-024 Redirect in VALID: flush the buffer; o_instr_valid=0 from the next cycle; go to REQ; a same-cycle i_instr_ready produces no +4 update.
REQ-025 Redirect in IDLE: update the PC; the next state is still REQ.
REQ-026 o_pc_write=0 in every other case; o_pc_next is don't-care when o_pc_write=0.
REQ-027 Stall: while VALID and i_instr_ready=0, the buffer, o_instr and o_instr_pc hold stable.
REQ-028 Minimum fetch-to-decode latency: grant in cycle N, rvalid in N+1, o_instr_valid in N+2.

Reset
REQ-029 While i_rst_n=0: state=IDLE, o_imem_req=0, o_instr_valid=0, o_pc_write=0, o_pc_next=RESET_PC, discard flag=0, buffer=0, o_misalign=0.
REQ-030 Asserting reset mid-operation aborts immediately; any rvalid for a request outstanding at reset is ignored after release.

Configuration
REQ-031 Macro PC_MISALIGN_TRAP_EN.
- Defined: a redirect target with bits[1:0] != 0 is replaced by i_trap_vec, and o_misalign pulses for 1 cycle.
- Undefined: targets pass through unchanged, and o_misalign is tied 0.

Verification
REQ-032 Reset release with RESET_PC=4000_0000 -> IDLE one cycle, then o_imem_req=1, o_imem_addr=4000_0000.
REQ-033 gnt@N, rvalid@N+1 with rdata=0000_0013, ready=1 -> o_instr_valid@N+2; o_pc_write with o_pc_next=4000_0004.
REQ-034 i_instr_ready=0 for 5 cycles in VALID -> o_instr stable; no o_pc_write until ready=1.
REQ-035 i_br_taken (target 4000_0100) in WAIT -> o_pc_write same cycle; the following rvalid is dropped; next request to 4000_0100.
REQ-036 i_trap (vec 0000_0080), i_mret and i_br_taken in the same cycle -> o_pc_next=0000_0080.
REQ-037 With PC_MISALIGN_TRAP_EN, branch target 4000_0102 -> o_pc_next=i_trap_vec, o_misalign pulse; without the macro -> o_pc_next=4000_0102.
